// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store initiator between the core memory stage and a word-wide data RAM
// Sub-word stores are read-modify-write because the RAM always writes all four lanes.
module dmem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic        illegal;
  logic [3:0]  sel_in;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_addr;

  // Byte-address bits above the RAM word range have no meaning to this RAM.
  assign unused_addr = ^addr[31:ADDR_W+2];

  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = addr[0];
      3'b010:  illegal = |addr[1:0];
      3'b100:  illegal = we;
      3'b101:  illegal = we | addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    sel_in = 4'b0000;
    case (funct3[1:0])
      2'b00:   sel_in = 4'b0001 << addr[1:0];
      2'b01:   sel_in = addr[1] ? 4'b1100 : 4'b0011;
      default: sel_in = 4'b1111;
    endcase
  end

  assign byte_val = ram_dout[{lat_off, 3'b000} +: 8];
  assign half_val = lat_off[1] ? ram_dout[31:16] : ram_dout[15:0];

  always_comb begin
    load_val = ram_dout;
    case (lat_f3)
      3'b000:  load_val = {{24{byte_val[7]}}, byte_val};
      3'b100:  load_val = {24'h000000, byte_val};
      3'b001:  load_val = {{16{half_val[15]}}, half_val};
      3'b101:  load_val = {16'h0000, half_val};
      default: load_val = ram_dout;
    endcase
  end

  always_comb begin
    merged = ram_dout;
    if (lat_f3[1:0] == 2'b00)
      merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata[15:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
      lat_wdata <= 16'h0000;
      rdata     <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= 32'h0;
      ram_we    <= 1'b0;
      ram_sel   <= 4'b0000;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      ram_we  <= 1'b0;
      ram_sel <= 4'b0000;
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_f3    <= funct3;
            lat_off   <= addr[1:0];
            lat_wdata <= wdata[15:0];
            ram_addr  <= addr[ADDR_W+1:2];
            rdata     <= 32'h0;
            busy      <= 1'b1;
            if (illegal) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (we && funct3[1:0] == 2'b10) begin
              state   <= WR;
              ram_we  <= 1'b1;
              ram_sel <= sel_in;
              ram_din <= wdata;
            end else begin
              state   <= RD;
              ram_sel <= sel_in;
            end
          end
        end
        RD: begin
          if (lat_we) begin
            state   <= WR;
            ram_we  <= 1'b1;
            ram_sel <= ram_sel;
            ram_din <= merged;
          end else begin
            state <= RESP;
            done  <= 1'b1;
            rdata <= load_val;
          end
        end
        WR: begin
          state <= RESP;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized bench for dmem_access_unit against a word-array memory model
module tb_dmem_access_unit;

  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RST;
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [3:0]        ram_sel;
  logic [31:0]       ram_dout;

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int vectors = 0;
  int errors  = 0;

  logic        chk_en = 1'b0;
  logic        e_busy, e_done, e_err, e_we;
  logic [3:0]  e_sel;
  logic        e_chk_rdata, e_chk_din, e_chk_addr;
  logic [31:0] e_rdata, e_din;
  logic [9:0]  e_addr;

  dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_dout(ram_dout)
  );

  always #5 CLK = ~CLK;

  assign ram_dout = ram[ram_addr];
  always @(posedge CLK) if (ram_we) ram[ram_addr] <= ram_din;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_sel", 32'(ram_sel), 32'(e_sel));
      if (e_done) chk("err", 32'(err), 32'(e_err));
      if (e_chk_rdata) chk("rdata", rdata, e_rdata);
      if (e_chk_din) chk("ram_din", ram_din, e_din);
      if (e_chk_addr) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    e_busy = 0; e_done = 0; e_err = 0; e_we = 0; e_sel = 4'b0000;
    e_chk_rdata = 0; e_rdata = 0; e_chk_din = 0; e_din = 0; e_chk_addr = 0; e_addr = 0;
  endtask

  task automatic set_reset_exp();
    set_idle();
    e_chk_rdata = 1; e_chk_din = 1; e_chk_addr = 1;
  endtask

  task automatic scramble();
    req = 1'($urandom); we = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
  endtask

  // rst_at: cycle after acceptance in which RST is raised (0 = never).
  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int rst_at,
                        output logic [31:0] got_rdata, output logic got_err);
    logic [9:0]  wi;
    int          nb, sh, n;
    bit          code_ok, ill;
    logic [31:0] old, mask, field, nw;
    logic [3:0]  sel;
    int          ph [3];
    wi = a[11:2];
    nb = (f[1:0] == 2'd3) ? 0 : (1 << f[1:0]);
    code_ok = w ? (f <= 3'd2) : (f != 3'd3 && f != 3'd6 && f != 3'd7);
    ill = !code_ok || ((int'(a[1:0]) % nb) != 0);
    sh = 8 * int'(a[1:0]);
    old = ref_mem[wi];
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    field = (old >> sh) & mask;
    if (!ill && !f[2] && nb < 4 && field[8*nb-1]) field = field | ~mask;
    nw = (old & ~(mask << sh)) | ((d & mask) << sh);
    sel = ill ? 4'b0000 : 4'(((1 << nb) - 1) << a[1:0]);
    // phase codes: 0 read, 1 write, 2 response
    if (ill)          begin n = 1; ph[0] = 2; end
    else if (!w)      begin n = 2; ph[0] = 0; ph[1] = 2; end
    else if (nb == 4) begin n = 2; ph[0] = 1; ph[1] = 2; end
    else              begin n = 3; ph[0] = 0; ph[1] = 1; ph[2] = 2; end
    got_rdata = 32'h0;
    got_err = 1'b0;

    req = 1; we = w; funct3 = f; addr = a; wdata = d;
    set_idle();
    for (int c = 1; c <= n; c++) begin
      step();
      scramble();
      set_idle();
      e_busy = 1; e_chk_addr = 1; e_addr = wi;
      if (ph[c-1] == 0) e_sel = sel;
      if (ph[c-1] == 1) begin e_we = 1; e_sel = sel; e_chk_din = 1; e_din = nw; end
      if (ph[c-1] == 2) begin
        e_done = 1; e_err = ill;
        if (ill || !w) begin e_chk_rdata = 1; e_rdata = ill ? 32'h0 : field; end
      end
      if (c == rst_at) begin
        RST = 1; req = 0;
        step();
        RST = 0;
        set_reset_exp();
        if (ph[c-1] == 1) ref_mem[wi] = nw;
        chk("mem_after_reset", ram[wi], ref_mem[wi]);
        step();
        set_idle();
        return;
      end
      if (ph[c-1] == 2) begin
        @(negedge CLK);
        got_rdata = rdata;
        got_err = err;
      end
    end
    step();
    req = 0;
    set_idle();
    if (!ill && w) ref_mem[wi] = nw;
    chk("mem", ram[wi], ref_mem[wi]);
  endtask

  logic [31:0] r;
  logic        e;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    RST = 1; req = 1; we = 1; funct3 = 3'b010; addr = 32'h10; wdata = 32'hDEADBEEF;
    set_reset_exp();
    step();
    chk_en = 1;
    step();
    RST = 0; req = 0;
    step();
    set_idle();
    step();

    access(1, 3'b010, 32'h10, 32'h12345678, 0, r, e);
    chk("lit_sw_err", 32'(e), 32'h0);
    chk("lit_sw_mem", ram[4], 32'h12345678);
    access(0, 3'b010, 32'h10, 32'h0, 0, r, e);
    chk("lit_lw", r, 32'h12345678);
    access(1, 3'b000, 32'h13, 32'h000000AB, 0, r, e);
    chk("lit_sb_mem", ram[4], 32'hAB345678);
    access(0, 3'b000, 32'h13, 32'h0, 0, r, e);
    chk("lit_lb", r, 32'hFFFFFFAB);
    access(0, 3'b100, 32'h13, 32'h0, 0, r, e);
    chk("lit_lbu", r, 32'h000000AB);
    access(0, 3'b000, 32'h10, 32'h0, 0, r, e);
    chk("lit_lb0", r, 32'h00000078);
    access(1, 3'b001, 32'h12, 32'h00008001, 0, r, e);
    chk("lit_sh_mem", ram[4], 32'h80015678);
    access(0, 3'b001, 32'h12, 32'h0, 0, r, e);
    chk("lit_lh", r, 32'hFFFF8001);
    access(0, 3'b101, 32'h12, 32'h0, 0, r, e);
    chk("lit_lhu", r, 32'h00008001);
    access(0, 3'b001, 32'h10, 32'h0, 0, r, e);
    chk("lit_lh0", r, 32'h00005678);

    access(0, 3'b010, 32'h11, 32'h0, 0, r, e);
    chk("lit_ill_lw_err", 32'(e), 32'h1);
    access(1, 3'b001, 32'h13, 32'hFFFFFFFF, 0, r, e);
    chk("lit_ill_sh_err", 32'(e), 32'h1);
    access(0, 3'b011, 32'h10, 32'h0, 0, r, e);
    chk("lit_ill_f3_err", 32'(e), 32'h1);
    access(1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, r, e);
    chk("lit_ill_sbu_err", 32'(e), 32'h1);
    chk("lit_ill_mem", ram[4], 32'h80015678);

    access(1, 3'b000, 32'h10, 32'h00000055, 1, r, e);
    chk("lit_rst_rd_mem", ram[4], 32'h80015678);
    access(1, 3'b010, 32'h20, 32'hCAFEF00D, 1, r, e);
    chk("lit_rst_wr_mem", ram[8], 32'hCAFEF00D);

    for (int t = 0; t < 400; t++) begin
      logic [31:0] ra;
      int          rs;
      ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      rs = ($urandom_range(0, 19) == 0) ? 1 + int'($urandom_range(0, 1)) : 0;
      access(1'($urandom), 3'($urandom), ra, $urandom, rs, r, e);
      if ($urandom_range(0, 3) == 0) step();
    end

    for (int i = 0; i < 16; i++) chk("final_mem", ram[i], ref_mem[i]);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
